// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, Rcon and the core FSM encoding.
// Optional feature macro used elsewhere in this slice: AES_ZEROIZE_EN.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } fsm_t;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Rcon[1..10], first entry in the most significant byte
    localparam logic [79:0] RCON_FLAT = 80'h01020408102040801b36;

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_FLAT[2047 - 8 * int'(a) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input int idx);
        return RCON_FLAT[79 - 8 * (idx - 1) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul02(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] mul03(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// MixColumns is bypassed for the final round (last_i=1).
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // byte i sits at row i%4, column i/4; byte 0 is the most significant
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state_i[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[r+4*c] = sb[r+4*((c+r)%4)];
        end

        assign mc[4*c+0] = mul02(sr[4*c]) ^ mul03(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ mul02(sr[4*c+1]) ^ mul03(sr[4*c+2]) ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ mul02(sr[4*c+2]) ^ mul03(sr[4*c+3]);
        assign mc[4*c+3] = mul03(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ mul02(sr[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign state_o[127-8*i -: 8] = (last_i ? sr[i] : mc[i]) ^ rkey_i[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_enc_iter_core.sv
// Iterative AES-128/192/256 encryptor, one round per clock, with a stored key schedule.
// Define AES_ZEROIZE_EN to add the synchronous zeroize input.
//   state | meaning
//   IDLE  | waiting for a key or a block; output buffer may still be full
//   KEXP  | expanding the key schedule, one word per cycle
//   ROUND | applying rounds 1..NR to the block in flight
//   HOLD  | result finished but output buffer still occupied
module aes_enc_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [127:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [127:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    fsm_t         fsm_q;
    logic         key_loaded_q;
    logic         out_valid_q;
    logic [127:0] out_data_q;
    logic [127:0] state_q;
    logic [31:0]  w_q [NW];
    logic [3:0]   rnd_q;
    logic [5:0]   wi_q;
    logic [2:0]   kmod_q;
    logic [3:0]   rci_q;

    logic         zero_req;
    logic         key_fire;
    logic         in_fire;
    logic [5:0]   rk_base;
    logic [127:0] rk0;
    logic [127:0] rk_rnd;
    logic [127:0] round_d;
    logic         last_rnd;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  kexp_tmp;
    logic [31:0]  w_new_d;

`ifdef AES_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // a pending block wins over a new key so a key never changes under a queued block
    assign key_ready = (fsm_q == IDLE) && !(in_valid && key_loaded_q);
    assign in_ready  = (fsm_q == IDLE) && key_loaded_q;
    assign key_fire  = key_valid && key_ready;
    assign in_fire   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign rk_base  = {rnd_q, 2'b00};
    assign rk0      = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign rk_rnd   = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    assign last_rnd = (rnd_q == 4'(NR));

    aes_round u_round (
        .state_i (state_q),
        .rkey_i  (rk_rnd),
        .last_i  (last_rnd),
        .state_o (round_d)
    );

    assign w_prev = w_q[wi_q - 6'd1];
    assign w_back = w_q[wi_q - 6'(NK)];

    always_comb begin
        kexp_tmp = w_prev;
        if (kmod_q == 3'd0) begin
            kexp_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(int'(rci_q)), 24'h0};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            kexp_tmp = sub_word(w_prev);
        end
    end

    assign w_new_d = w_back ^ kexp_tmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            state_q      <= '0;
            rnd_q        <= '0;
            wi_q         <= '0;
            kmod_q       <= '0;
            rci_q        <= '0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (zero_req) begin
            fsm_q        <= IDLE;
            key_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            state_q      <= '0;
            rnd_q        <= '0;
            wi_q         <= '0;
            kmod_q       <= '0;
            rci_q        <= '0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            // consumer drain; a result loaded below on the same edge overrides it
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (fsm_q)
                IDLE: begin
                    if (in_fire) begin
                        state_q <= in_data ^ rk0;
                        rnd_q   <= 4'd1;
                        fsm_q   <= ROUND;
                    end else if (key_fire) begin
                        for (int k = 0; k < NK; k++) begin
                            w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
                        end
                        key_loaded_q <= 1'b0;
                        wi_q         <= 6'(NK);
                        kmod_q       <= 3'd0;
                        rci_q        <= 4'd1;
                        fsm_q        <= KEXP;
                    end
                end

                KEXP: begin
                    w_q[wi_q] <= w_new_d;
                    wi_q      <= wi_q + 6'd1;
                    if (kmod_q == 3'(NK - 1)) begin
                        kmod_q <= 3'd0;
                        rci_q  <= rci_q + 4'd1;
                    end else begin
                        kmod_q <= kmod_q + 3'd1;
                    end
                    if (wi_q == 6'(NW - 1)) begin
                        key_loaded_q <= 1'b1;
                        fsm_q        <= IDLE;
                    end
                end

                ROUND: begin
                    if (last_rnd) begin
                        if (!out_valid_q || out_ready) begin
                            out_data_q  <= round_d;
                            out_valid_q <= 1'b1;
                            fsm_q       <= IDLE;
                        end else begin
                            state_q <= round_d;
                            fsm_q   <= HOLD;
                        end
                    end else begin
                        state_q <= round_d;
                        rnd_q   <= rnd_q + 4'd1;
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        out_data_q  <= state_q;
                        out_valid_q <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end

                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// Directed bench for aes_enc_iter_core: one instance per key length, known-answer vectors,
// handshake timing, backpressure, priority and reset abort (zeroize when AES_ZEROIZE_EN is defined).
module tb_aes_enc_iter_core;

    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KSP    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1     = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2     = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_bus;
    logic [127:0] in_data;
    logic         out_ready;
    logic         kv [3];
    logic         iv [3];
    logic         kr [3];
    logic         ir [3];
    logic         ov [3];
    logic [127:0] od [3];
`ifdef AES_ZEROIZE_EN
    logic         zeroize;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_enc_iter_core #(.KEY_BITS(128)) u_aes128 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_in(key_bus[255:128]), .key_valid(kv[0]), .key_ready(kr[0]),
        .in_data(in_data), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready)
    );

    aes_enc_iter_core #(.KEY_BITS(192)) u_aes192 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_in(key_bus[255:64]), .key_valid(kv[1]), .key_ready(kr[1]),
        .in_data(in_data), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready)
    );

    aes_enc_iter_core #(.KEY_BITS(256)) u_aes256 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key_in(key_bus), .key_valid(kv[2]), .key_ready(kr[2]),
        .in_data(in_data), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // busy = number of sampled cycles key_ready stays low after the accepting edge
    task automatic load_key(input int n, input logic [255:0] key, output int busy);
        int t;
        t = 0;
        key_bus = key;
        kv[n] = 1'b1;
        #1;
        while (!kr[n] && t < 100) begin
            tick();
            t++;
        end
        check("key_ready_wait", 128'(kr[n]), 128'(1));
        tick();
        kv[n] = 1'b0;
        busy = 0;
        while (!kr[n] && busy < 200) begin
            tick();
            busy++;
        end
    endtask

    task automatic send(input int n, input logic [127:0] pt);
        int t;
        t = 0;
        while (!ir[n] && t < 200) begin
            tick();
            t++;
        end
        check("in_ready_wait", 128'(ir[n]), 128'(1));
        in_data = pt;
        iv[n] = 1'b1;
        tick();
        iv[n] = 1'b0;
    endtask

    // lat counts edges with the accepting edge as edge 1
    task automatic wait_out(input int n, output int lat);
        lat = 1;
        while (!ov[n] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop(input int n, input logic [127:0] exp, input string tag);
        check(tag, od[n], exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int busy;
        int lat;
        int nacc;
        int nout;
        int cyc;
        int acc_t [3];

        rst_n     = 1'b0;
        key_bus   = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            kv[i] = 1'b0;
            iv[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 128'(ov[i]), 128'(0));
            check("rst_out_data", od[i], 128'h0);
            check("rst_in_ready", 128'(ir[i]), 128'(0));
            check("rst_key_ready", 128'(kr[i]), 128'(1));
        end
        rst_n = 1'b1;
        tick();

        // T1: AES-128 known answer and latency
        load_key(0, K128, busy);
        check("t1_kexp_cycles", 128'(busy), 128'(40));
        send(0, PT);
        wait_out(0, lat);
        check("t1_latency", 128'(lat), 128'(11));
        pop(0, CT128, "t1_ct");
        check("t1_out_valid_drop", 128'(ov[0]), 128'(0));

        // T2: AES-192
        load_key(1, K192, busy);
        check("t2_kexp_cycles", 128'(busy), 128'(46));
        send(1, PT);
        wait_out(1, lat);
        check("t2_latency", 128'(lat), 128'(13));
        pop(1, CT192, "t2_ct");

        // T3: AES-256, three back-to-back blocks with the consumer always ready
        load_key(2, K256, busy);
        check("t3_kexp_cycles", 128'(busy), 128'(52));
        out_ready = 1'b1;
        in_data   = PT;
        iv[2]     = 1'b1;
        nacc = 0;
        nout = 0;
        cyc  = 0;
        #1;
        while ((nacc < 3 || nout < 3) && cyc < 200) begin
            if (iv[2] && ir[2]) begin
                acc_t[nacc] = cyc;
                nacc++;
            end
            if (ov[2]) begin
                check("t3_ct", od[2], CT256);
                nout++;
            end
            tick();
            cyc++;
            if (nacc == 3) iv[2] = 1'b0;
        end
        iv[2]     = 1'b0;
        out_ready = 1'b0;
        check("t3_accepts", 128'(nacc), 128'(3));
        check("t3_outputs", 128'(nout), 128'(3));
        check("t3_spacing_1", 128'(acc_t[1] - acc_t[0]), 128'(15));
        check("t3_spacing_2", 128'(acc_t[2] - acc_t[1]), 128'(15));

        // T4: backpressure; second result parks in HOLD behind the first
        load_key(0, KSP, busy);
        send(0, P1);
        wait_out(0, lat);
        check("t4_latency", 128'(lat), 128'(11));
        send(0, P2);
        repeat (30) tick();
        check("t4_held_valid", 128'(ov[0]), 128'(1));
        check("t4_held_ct1", od[0], C1);
        check("t4_hold_in_ready", 128'(ir[0]), 128'(0));
        out_ready = 1'b1;
        tick();
        check("t4_second_valid", 128'(ov[0]), 128'(1));
        check("t4_second_ct2", od[0], C2);
        tick();
        out_ready = 1'b0;
        check("t4_drained", 128'(ov[0]), 128'(0));

        // T5a: block wins over a simultaneous key offer; old key stays in use
        key_bus   = K128;
        in_data   = P1;
        kv[0]     = 1'b1;
        iv[0]     = 1'b1;
        #1;
        check("t5_key_ready_blocked", 128'(kr[0]), 128'(0));
        check("t5_in_ready", 128'(ir[0]), 128'(1));
        tick();
        kv[0] = 1'b0;
        iv[0] = 1'b0;
        wait_out(0, lat);
        check("t5_latency", 128'(lat), 128'(11));
        pop(0, C1, "t5_ct_old_key");

        // T5b: reset during round 5 aborts everything
        send(0, P2);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 128'(ov[0]), 128'(0));
        check("t5_rst_in_ready", 128'(ir[0]), 128'(0));
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t5_post_out_valid", 128'(ov[0]), 128'(0));
        check("t5_post_out_data", od[0], 128'h0);
        check("t5_post_in_ready", 128'(ir[0]), 128'(0));
        load_key(0, K128, busy);
        check("t5_reload_cycles", 128'(busy), 128'(40));
        send(0, PT);
        wait_out(0, lat);
        pop(0, CT128, "t5_reload_ct");

`ifdef AES_ZEROIZE_EN
        // T6: zeroize with a result waiting and a block mid-round
        send(0, PT);
        wait_out(0, lat);
        send(0, P1);
        repeat (3) tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("t6_out_valid", 128'(ov[0]), 128'(0));
        check("t6_out_data", od[0], 128'h0);
        check("t6_in_ready", 128'(ir[0]), 128'(0));
        load_key(0, K128, busy);
        send(0, PT);
        wait_out(0, lat);
        check("t6_latency", 128'(lat), 128'(11));
        pop(0, CT128, "t6_reload_ct");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
